pc_seq: RTL and testbench
=========================

// Module: pc_seq
// PURPOSE
//  Parametrised program-counter sequencer for the single-cycle RISC-V core; successor to the fixed 32-bit PC.
//  Resolves next PC from control-unit op, ALU flags, rs1 and immediate; advances only when fetch is ready.
//  Adds reset/trap vectors, misaligned-target trap FSM, link-value output and retired-instruction counter.
// PARAMETERS
//  XLEN          32            address/data width
//  RESET_VECTOR  32'h0000_0000 PC value while in reset and first cycle after release
//  TRAP_VECTOR   32'h0000_0100 PC loaded on misaligned jump/branch target
//  CNT_W         32            width of instret counter
// PORTS
//  clk           in   1         core clock, all state on rising edge
//  nRST          in   1         asynchronous active-low reset
//  cuOP          in   cuOPType  decoded op (CU_JAL, CU_JALR, CU_BEQ..CU_BGEU, others = sequential)
//  rs1Read       in   XLEN      rs1 operand (JALR base)
//  signExtend    in   XLEN      sign-extended immediate (branch/jump offset)
//  ALUneg        in   1         ALU compare result negative / less-than
//  Zero          in   1         ALU compare result zero / equal
//  iready        in   1         instruction valid for current PCaddr; 0 = stall
//  PCaddr        out  XLEN      current fetch address (registered)
//  pcPlus4       out  XLEN      PCaddr+4, link value for JAL/JALR (combinational)
//  redirect      out  1         next PC is non-sequential this cycle (combinational, gated by iready)
//  misalignTrap  out  1         registered 1-cycle pulse: trap taken on previous edge
//  instret       out  CNT_W     count of retired (iready=1, non-trap) instructions
// BEHAVIOUR
//  Reset (nRST=0, async): PCaddr=RESET_VECTOR, misalignTrap=0, instret=0, state=RUN.
//  Target: JAL -> PCaddr+signExtend; JALR -> (rs1Read+signExtend)&~1; branch taken -> PCaddr+signExtend;
//   otherwise PCaddr+4. All sums modulo 2^XLEN (wrap silently, no carry out).
//  Branch taken: BEQ Zero; BNE !Zero; BLT/BLTU ALUneg; BGE/BGEU !ALUneg|Zero.
//  Misaligned: target[1:0]!=0 on JAL/JALR/taken branch (JALR bit0 already cleared, so bit1 only).
//  FSM states RUN, TRAP:
//   RUN, iready=0: hold PCaddr, instret, state; redirect=0; flags ignored.
//   RUN, iready=1, aligned: PCaddr<=target; instret<=instret+1 (wraps at 2^CNT_W); stay RUN.
//   RUN, iready=1, misaligned: PCaddr<=TRAP_VECTOR; instret unchanged; misalignTrap<=1; ->TRAP.
//   TRAP (exactly 1 cycle): misalignTrap<=0; redirect=0; PCaddr held regardless of iready; ->RUN.
//  Non-branch ops (CU_LUI etc.) are always sequential; never trap.
//  redirect=1 iff state=RUN, iready=1, target != PCaddr+4 path (jump or taken branch), incl. trap case.
//  Latency: new PC visible one clk after decision edge; pcPlus4/redirect track PCaddr same cycle.
//  Reset asserted mid-TRAP or mid-stall: immediate return to reset values, no pending state kept.
// CONFIGURATION
//  PC_LAST_REDIRECT_EN defined: extra outputs lastSrc[XLEN], lastDst[XLEN], both reset 0; on every
//   RUN redirect with iready=1 lastSrc<=PCaddr, lastDst<=taken target (pre-trap, pre-vector value).
//  Not defined: ports absent, no registers; all other behaviour identical.
// TESTING
//  nRST=0 for 2 clk, release -> PCaddr=RESET_VECTOR (0), instret=0, misalignTrap=0 during and after.
//  CU_LUI, iready=1 for 5 clk -> PCaddr 0,4,8,12,16,20; instret=5; then iready=0 3 clk -> PCaddr/instret hold.
//  PC=0x40, CU_BEQ imm=0x20: Zero=0 -> 0x44; Zero=1 -> 0x60; CU_BGE ALUneg=1,Zero=1 -> taken, redirect=1.
//  CU_JALR rs1=0x1001, imm=0x10 -> PCaddr=0x1010, pcPlus4 prior cycle=PC+4; instret+1.
//  PC=0x40, CU_JAL imm=0x6 -> PCaddr=TRAP_VECTOR 0x100, misalignTrap=1 one clk, instret unchanged, PC holds 1 clk.
//  PC=0xFFFF_FFFC, sequential -> PCaddr=0 wrap; instret at 2^CNT_W-1 +1 -> 0; nRST pulsed during TRAP -> reset values.

Source files
------------

// File: rtl/pc_seq.sv
// pc_seq: program-counter sequencer for the single-cycle RISC-V core.
//   Resolves the next fetch address from the decoded op, the ALU compare flags, rs1 and the
//   immediate. It advances only when fetch reports iready. A jump or taken branch to a
//   misaligned target vectors to TRAP_VECTOR and spends one cycle in a trap state.
//
// Ports
//   clk           core clock, all state on rising edge
//   nRST          asynchronous active-low reset
//   cuOP[3:0]     decoded op: 1 JAL, 2 JALR, 3 BEQ, 4 BNE, 5 BLT, 6 BGE, 7 BLTU, 8 BGEU;
//                 any other code (LUI, ALU ops, ...) is sequential
//   rs1Read       JALR base operand
//   signExtend    sign-extended branch/jump offset
//   ALUneg, Zero  ALU compare result (less-than, equal)
//   iready        instruction valid for PCaddr; 0 = stall
//   PCaddr        registered fetch address
//   pcPlus4       PCaddr + 4, link value (combinational)
//   redirect      non-sequential next PC this cycle, trap case included (combinational)
//   misalignTrap  one-cycle registered pulse, high while in the trap cycle
//   instret       retired-instruction counter, wraps at 2^CNT_W
//
// Optional feature: define PC_LAST_REDIRECT_EN to add lastSrc/lastDst. These outputs record
// the source PC and the raw taken target of the most recent redirect.
module pc_seq #(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}},
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
   parameter int unsigned     CNT_W        = 32
) (
   input  logic             clk,
   input  logic             nRST,
   input  logic [3:0]       cuOP,
   input  logic [XLEN-1:0]  rs1Read,
   input  logic [XLEN-1:0]  signExtend,
   input  logic             ALUneg,
   input  logic             Zero,
   input  logic             iready,
   output logic [XLEN-1:0]  PCaddr,
   output logic [XLEN-1:0]  pcPlus4,
   output logic             redirect,
   output logic             misalignTrap,
   output logic [CNT_W-1:0] instret
`ifdef PC_LAST_REDIRECT_EN
   ,
   output logic [XLEN-1:0]  lastSrc,
   output logic [XLEN-1:0]  lastDst
`endif
);

   localparam logic [3:0] CU_JAL  = 4'd1;
   localparam logic [3:0] CU_JALR = 4'd2;
   localparam logic [3:0] CU_BEQ  = 4'd3;
   localparam logic [3:0] CU_BNE  = 4'd4;
   localparam logic [3:0] CU_BLT  = 4'd5;
   localparam logic [3:0] CU_BGE  = 4'd6;
   localparam logic [3:0] CU_BLTU = 4'd7;
   localparam logic [3:0] CU_BGEU = 4'd8;

   typedef enum logic {StRun, StTrap} state_e;

   state_e          state;
   logic            taken;
   logic            misalign;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] rel_tgt;
   logic [XLEN-1:0] jalr_sum;
   logic [XLEN-1:0] jalr_tgt;

   assign pcPlus4  = PCaddr + XLEN'(4);
   assign rel_tgt  = PCaddr + signExtend;
   assign jalr_sum = rs1Read + signExtend;
   assign jalr_tgt = {jalr_sum[XLEN-1:1], 1'b0};

   always_comb begin
      taken  = 1'b0;
      target = pcPlus4;
      case (cuOP)
         CU_JAL, CU_JALR:  taken = 1'b1;
         CU_BEQ:           taken = Zero;
         CU_BNE:           taken = ~Zero;
         CU_BLT, CU_BLTU:  taken = ALUneg;
         CU_BGE, CU_BGEU:  taken = ~ALUneg | Zero;
         default:          taken = 1'b0;
      endcase
      if (taken) begin
         target = (cuOP == CU_JALR) ? jalr_tgt : rel_tgt;
      end
   end

   // JALR has bit 0 already cleared, so for it only bit 1 can flag misalignment.
   assign misalign = taken & (target[1:0] != 2'b00);
   assign redirect = (state == StRun) & iready & taken;

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state        <= StRun;
         PCaddr       <= RESET_VECTOR;
         misalignTrap <= 1'b0;
         instret      <= '0;
`ifdef PC_LAST_REDIRECT_EN
         lastSrc      <= '0;
         lastDst      <= '0;
`endif
      end else begin
         case (state)
            StRun: begin
               if (iready) begin
                  if (misalign) begin
                     // Trapped instruction does not retire.
                     PCaddr       <= TRAP_VECTOR;
                     misalignTrap <= 1'b1;
                     state        <= StTrap;
                  end else begin
                     PCaddr  <= target;
                     instret <= instret + CNT_W'(1);
                  end
`ifdef PC_LAST_REDIRECT_EN
                  if (taken) begin
                     lastSrc <= PCaddr;
                     lastDst <= target;
                  end
`endif
               end
            end
            StTrap: begin
               // PCaddr holds at the vector for one cycle whatever iready says.
               misalignTrap <= 1'b0;
               state        <= StRun;
            end
            default: state <= StRun;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_seq.sv
module tb_pc_seq;

   localparam int unsigned CNT_W = 4;
   localparam logic [31:0] RV    = 32'h0000_0000;
   localparam logic [31:0] TV    = 32'h0000_0100;

   localparam logic [3:0] CU_LUI  = 4'd0;
   localparam logic [3:0] CU_JAL  = 4'd1;
   localparam logic [3:0] CU_JALR = 4'd2;
   localparam logic [3:0] CU_BEQ  = 4'd3;
   localparam logic [3:0] CU_BNE  = 4'd4;
   localparam logic [3:0] CU_BLT  = 4'd5;
   localparam logic [3:0] CU_BGE  = 4'd6;
   localparam logic [3:0] CU_BLTU = 4'd7;
   localparam logic [3:0] CU_BGEU = 4'd8;

   logic             tb_clk = 1'b0;
   logic             nRST;
   logic [3:0]       cuOP;
   logic [31:0]      rs1Read;
   logic [31:0]      signExtend;
   logic             ALUneg;
   logic             Zero;
   logic             iready;
   logic [31:0]      PCaddr;
   logic [31:0]      pcPlus4;
   logic             redirect;
   logic             misalignTrap;
   logic [CNT_W-1:0] instret;
`ifdef PC_LAST_REDIRECT_EN
   logic [31:0]      lastSrc;
   logic [31:0]      lastDst;
`endif

   pc_seq #(
      .XLEN         (32),
      .RESET_VECTOR (RV),
      .TRAP_VECTOR  (TV),
      .CNT_W        (CNT_W)
   ) dut (
      .clk          (tb_clk),
      .nRST         (nRST),
      .cuOP         (cuOP),
      .rs1Read      (rs1Read),
      .signExtend   (signExtend),
      .ALUneg       (ALUneg),
      .Zero         (Zero),
      .iready       (iready),
      .PCaddr       (PCaddr),
      .pcPlus4      (pcPlus4),
      .redirect     (redirect),
      .misalignTrap (misalignTrap),
      .instret      (instret)
`ifdef PC_LAST_REDIRECT_EN
      ,
      .lastSrc      (lastSrc),
      .lastDst      (lastDst)
`endif
   );

   always #5 tb_clk = ~tb_clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference rules: does this op leave the sequential path, and where does it go.
   function automatic bit f_jump(input logic [3:0] op, input logic neg, input logic zero);
      if (op == CU_JAL || op == CU_JALR) return 1'b1;
      if (op == CU_BEQ) return zero;
      if (op == CU_BNE) return !zero;
      if (op == CU_BLT || op == CU_BLTU) return neg;
      if (op == CU_BGE || op == CU_BGEU) return !neg || zero;
      return 1'b0;
   endfunction

   function automatic logic [31:0] f_tgt(input logic [3:0] op, input logic [31:0] pc,
                                         input logic [31:0] rs1, input logic [31:0] imm,
                                         input logic neg, input logic zero);
      if (!f_jump(op, neg, zero)) return pc + 32'd4;
      if (op == CU_JALR) return (rs1 + imm) & 32'hFFFF_FFFE;
      return pc + imm;
   endfunction

   function automatic bit f_mis(input logic [3:0] op, input logic [31:0] pc,
                                input logic [31:0] rs1, input logic [31:0] imm,
                                input logic neg, input logic zero);
      return f_jump(op, neg, zero) && ((f_tgt(op, pc, rs1, imm, neg, zero) % 4) != 0);
   endfunction

   // Model state: fetch address, retired count, and whether this is the trap cycle.
   logic [31:0]      m_pc;
   logic [CNT_W-1:0] m_cnt;
   bit               m_trap;

   always @(posedge tb_clk or negedge nRST) begin
      if (!nRST) begin
         m_pc   <= RV;
         m_cnt  <= '0;
         m_trap <= 1'b0;
      end else if (m_trap) begin
         m_trap <= 1'b0;
      end else if (iready) begin
         if (f_mis(cuOP, m_pc, rs1Read, signExtend, ALUneg, Zero)) begin
            m_pc   <= TV;
            m_trap <= 1'b1;
         end else begin
            m_pc  <= f_tgt(cuOP, m_pc, rs1Read, signExtend, ALUneg, Zero);
            m_cnt <= m_cnt + 1'b1;
         end
      end
   end

   always @(negedge tb_clk) begin
      if (chk_en) begin
         check("PCaddr", PCaddr, m_pc);
         check("pcPlus4", pcPlus4, 32'(m_pc + 32'd4));
         check("redirect", redirect,
               !m_trap && iready && f_jump(cuOP, ALUneg, Zero));
         check("misalignTrap", misalignTrap, m_trap);
         check("instret", instret, m_cnt);
      end
   end

   task automatic drive(input logic [3:0] op, input logic [31:0] rs1, input logic [31:0] imm,
                        input logic neg, input logic zero, input logic rdy);
      cuOP       = op;
      rs1Read    = rs1;
      signExtend = imm;
      ALUneg     = neg;
      Zero       = zero;
      iready     = rdy;
   endtask

   task automatic tick();
      @(posedge tb_clk);
      #1;
   endtask

   initial begin
      nRST = 1'b0;
      drive(CU_LUI, 0, 0, 0, 0, 0);
      tick();
      chk_en = 1'b1;
      tick();
      check("rst_pc", PCaddr, 32'h0);
      check("rst_cnt", instret, 0);
      check("rst_trap", misalignTrap, 0);

      // Sequential run, then stall.
      nRST = 1'b1;
      drive(CU_LUI, 0, 0, 0, 0, 1);
      repeat (5) tick();
      check("seq_pc", PCaddr, 32'd20);
      check("seq_cnt", instret, 5);
      check("seq_trap", misalignTrap, 0);
      drive(CU_LUI, 0, 0, 0, 0, 0);
      repeat (3) tick();
      check("stall_pc", PCaddr, 32'd20);
      check("stall_cnt", instret, 5);

      // Reach 0x40, then branches.
      drive(CU_JAL, 0, 32'h2C, 0, 0, 1);
      tick();
      check("jal_pc", PCaddr, 32'h40);
      drive(CU_BEQ, 0, 32'h20, 0, 0, 1);
      #1 check("beq_nt_redir", redirect, 0);
      tick();
      check("beq_nt_pc", PCaddr, 32'h44);
      drive(CU_JAL, 0, 32'hFFFF_FFFC, 0, 0, 1);
      tick();
      check("jal_back_pc", PCaddr, 32'h40);
      drive(CU_BEQ, 0, 32'h20, 0, 1, 1);
      #1 check("beq_t_redir", redirect, 1);
      tick();
      check("beq_t_pc", PCaddr, 32'h60);
      drive(CU_BGE, 0, 32'h20, 1, 1, 1);
      #1 check("bge_redir", redirect, 1);
      tick();
      check("bge_pc", PCaddr, 32'h80);
      drive(CU_BNE, 0, 32'h6, 0, 1, 1);
      tick();
      check("bne_nt_pc", PCaddr, 32'h84);
      check("bne_nt_trap", misalignTrap, 0);

      // JALR clears bit 0.
      drive(CU_JALR, 32'h1001, 32'h10, 0, 0, 1);
      #1 check("jalr_link", pcPlus4, 32'h88);
      tick();
      check("jalr_pc", PCaddr, 32'h1010);
      check("jalr_cnt", instret, 12);

      // Misaligned JAL from 0x40.
      drive(CU_JAL, 0, 32'hFFFF_F030, 0, 0, 1);
      tick();
      check("jal40_pc", PCaddr, 32'h40);
      drive(CU_JAL, 0, 32'h6, 0, 0, 1);
      #1 check("mis_redir", redirect, 1);
      tick();
      check("trap_pc", PCaddr, 32'h100);
      check("trap_pulse", misalignTrap, 1);
      check("trap_cnt", instret, 13);
      check("trap_redir", redirect, 0);
      tick();
      check("trap_hold_pc", PCaddr, 32'h100);
      check("trap_end", misalignTrap, 0);
      check("trap_hold_cnt", instret, 13);

      // PC wrap and counter wrap.
      drive(CU_JALR, 32'hFFFF_FFFC, 0, 0, 0, 1);
      tick();
      check("top_pc", PCaddr, 32'hFFFF_FFFC);
      drive(CU_LUI, 0, 0, 0, 0, 1);
      tick();
      check("wrap_pc", PCaddr, 32'h0);
      check("cnt_max", instret, 15);
      tick();
      check("cnt_wrap", instret, 0);
      check("pc_after_wrap", PCaddr, 32'h4);

      // Reset asserted during the trap cycle.
      drive(CU_JAL, 0, 32'h6, 0, 0, 1);
      tick();
      check("trap2_pulse", misalignTrap, 1);
      nRST = 1'b0;
      #1;
      check("rst_trap_pc", PCaddr, 32'h0);
      check("rst_trap_pulse", misalignTrap, 0);
      check("rst_trap_cnt", instret, 0);
      tick();
      nRST = 1'b1;
      drive(CU_LUI, 0, 0, 0, 0, 1);
      tick();
      check("post_rst_pc", PCaddr, 32'h4);
      check("post_rst_cnt", instret, 1);
      tick();
      chk_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
